// File: rtl/ysyx_23060229_axi_rd_arbiter.sv
// Two-master AXI4 read-channel arbiter (m0 = IFU, m1 = LSU) with a single outstanding burst.
// Define YSYX_23060229_ARB_RR_EN for round-robin arbitration; otherwise m1 has fixed priority.
module ysyx_23060229_axi_rd_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] m0_araddr,
    input  logic [3:0]    m0_arid,
    input  logic [7:0]    m0_arlen,
    input  logic [2:0]    m0_arsize,
    input  logic [1:0]    m0_arburst,
    input  logic          m0_arvalid,
    output logic          m0_arready,
    output logic [DW-1:0] m0_rdata,
    output logic [1:0]    m0_rresp,
    output logic          m0_rlast,
    output logic [3:0]    m0_rid,
    output logic          m0_rvalid,
    input  logic          m0_rready,
    input  logic [AW-1:0] m1_araddr,
    input  logic [3:0]    m1_arid,
    input  logic [7:0]    m1_arlen,
    input  logic [2:0]    m1_arsize,
    input  logic [1:0]    m1_arburst,
    input  logic          m1_arvalid,
    output logic          m1_arready,
    output logic [DW-1:0] m1_rdata,
    output logic [1:0]    m1_rresp,
    output logic          m1_rlast,
    output logic [3:0]    m1_rid,
    output logic          m1_rvalid,
    input  logic          m1_rready,
    output logic [AW-1:0] s_araddr,
    output logic [3:0]    s_arid,
    output logic [7:0]    s_arlen,
    output logic [2:0]    s_arsize,
    output logic [1:0]    s_arburst,
    output logic          s_arvalid,
    input  logic          s_arready,
    input  logic [DW-1:0] s_rdata,
    input  logic [1:0]    s_rresp,
    input  logic          s_rlast,
    input  logic [3:0]    s_rid,
    input  logic          s_rvalid,
    output logic          s_rready,
    output logic          busy,
    output logic          rid_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic       grant_q, grant_d;
    logic [3:0] arid_q, arid_d;
    logic       rid_err_q, rid_err_d;
`ifdef YSYX_23060229_ARB_RR_EN
    logic       last_grant_q, last_grant_d;
`endif

    logic winner_s;
    logic gnt_arvalid_s;
    logic gnt_rready_s;
    logic r_fire_s;

    assign gnt_arvalid_s = grant_q ? m1_arvalid : m0_arvalid;
    assign gnt_rready_s  = grant_q ? m1_rready  : m0_rready;
    assign r_fire_s      = (state_q == S_R) & s_rvalid & gnt_rready_s;

    // Arbitration winner among the masters requesting this cycle
    always_comb begin
        winner_s = 1'b0;
`ifdef YSYX_23060229_ARB_RR_EN
        if (m0_arvalid && m1_arvalid) begin
            winner_s = ~last_grant_q;
        end else begin
            winner_s = m1_arvalid;
        end
`else
        winner_s = m1_arvalid;
`endif
    end

    // Next-state, grant and ID-check logic
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        arid_d    = arid_q;
        rid_err_d = rid_err_q | (r_fire_s & (s_rid != arid_q));
`ifdef YSYX_23060229_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (m0_arvalid || m1_arvalid) begin
                    state_d = S_AR;
                    grant_d = winner_s;
                    arid_d  = winner_s ? m1_arid : m0_arid;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_AR: begin
                // A withdrawn request (e.g. fetch flush) abandons the grant before anything reaches the slave
                if (!gnt_arvalid_s) begin
                    state_d = S_IDLE;
                end else if (s_arready) begin
                    state_d = S_R;
                end else begin
                    state_d = S_AR;
                end
            end
            S_R: begin
                if (r_fire_s && s_rlast) begin
                    state_d = S_IDLE;
`ifdef YSYX_23060229_ARB_RR_EN
                    last_grant_d = grant_q;
`endif
                end else begin
                    state_d = S_R;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and bookkeeping registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            grant_q   <= 1'b0;
            arid_q    <= 4'd0;
            rid_err_q <= 1'b0;
`ifdef YSYX_23060229_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            arid_q    <= arid_d;
            rid_err_q <= rid_err_d;
`ifdef YSYX_23060229_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Channel routing; everything is quiet outside the phase that owns it
    always_comb begin
        s_araddr   = {AW{1'b0}};
        s_arid     = 4'd0;
        s_arlen    = 8'd0;
        s_arsize   = 3'd0;
        s_arburst  = 2'd0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        case (state_q)
            S_AR: begin
                s_araddr   = grant_q ? m1_araddr  : m0_araddr;
                s_arid     = grant_q ? m1_arid    : m0_arid;
                s_arlen    = grant_q ? m1_arlen   : m0_arlen;
                s_arsize   = grant_q ? m1_arsize  : m0_arsize;
                s_arburst  = grant_q ? m1_arburst : m0_arburst;
                s_arvalid  = gnt_arvalid_s;
                m0_arready = ~grant_q & s_arready;
                m1_arready = grant_q & s_arready;
            end
            S_R: begin
                s_rready  = gnt_rready_s;
                m0_rvalid = ~grant_q & s_rvalid;
                m1_rvalid = grant_q & s_rvalid;
            end
            default: begin
                s_arvalid = 1'b0;
            end
        endcase
    end

    assign m0_rdata = s_rdata;
    assign m0_rresp = s_rresp;
    assign m0_rlast = s_rlast;
    assign m0_rid   = s_rid;
    assign m1_rdata = s_rdata;
    assign m1_rresp = s_rresp;
    assign m1_rlast = s_rlast;
    assign m1_rid   = s_rid;
    assign busy     = (state_q != S_IDLE);
    assign rid_err  = rid_err_q;

endmodule

// File: tb/tb_ysyx_23060229_axi_rd_arbiter.sv
// Scoreboard bench for the read arbiter: directed requests push expected AR/R traffic,
// a negedge monitor pops and compares it; a small slave model returns data = araddr + beat.
module tb_ysyx_23060229_axi_rd_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] m0_araddr, m1_araddr, s_araddr;
    logic [3:0]  m0_arid, m1_arid, s_arid;
    logic [7:0]  m0_arlen, m1_arlen, s_arlen;
    logic [2:0]  m0_arsize, m1_arsize, s_arsize;
    logic [1:0]  m0_arburst, m1_arburst, s_arburst;
    logic        m0_arvalid, m1_arvalid, s_arvalid;
    logic        m0_arready, m1_arready, s_arready;
    logic [31:0] m0_rdata, m1_rdata, s_rdata;
    logic [1:0]  m0_rresp, m1_rresp, s_rresp;
    logic        m0_rlast, m1_rlast, s_rlast;
    logic [3:0]  m0_rid, m1_rid, s_rid;
    logic        m0_rvalid, m1_rvalid, s_rvalid;
    logic        m0_rready, m1_rready, s_rready;
    logic        busy, rid_err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    ysyx_23060229_axi_rd_arbiter #(.AW(32), .DW(32)) dut (
        .clock(clock), .reset(reset),
        .m0_araddr(m0_araddr), .m0_arid(m0_arid), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
        .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rid(m0_rid),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arid(m1_arid), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
        .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rid(m1_rid),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rid(s_rid),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .busy(busy), .rid_err(rid_err)
    );

    typedef struct { bit m; logic [31:0] addr; logic [3:0] id; logic [7:0] len; } ar_exp_t;
    typedef struct { bit m; logic [31:0] data; logic [3:0] rid; bit last; } r_exp_t;
    ar_exp_t ar_q[$];
    r_exp_t  r_q[$];
    ar_exp_t ea;
    r_exp_t  er;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic void push_exp(input bit m, input logic [31:0] a, input logic [3:0] id,
                                     input logic [7:0] len, input bit bad_rid0);
        ar_q.push_back('{m: m, addr: a, id: id, len: len});
        for (int b = 0; b <= int'(len); b++)
            r_q.push_back('{m: m, data: a + 32'(b), rid: (bad_rid0 && b == 0) ? 4'd2 : id,
                            last: (b == int'(len))});
    endfunction

    // Slave model: accepts AR, then streams len+1 beats with data = araddr + beat
    bit          corrupt0 = 1'b0;
    logic        sl_act = 1'b0;
    logic [31:0] sl_addr;
    logic [3:0]  sl_id;
    logic [7:0]  sl_len, sl_beat;
    initial begin
        bit ar_hs, r_hs;
        logic [31:0] a_cap; logic [3:0] id_cap; logic [7:0] len_cap;
        s_rvalid = 1'b0; s_rdata = 32'd0; s_rresp = 2'd0; s_rlast = 1'b0; s_rid = 4'd0;
        sl_addr = 32'd0; sl_id = 4'd0; sl_len = 8'd0; sl_beat = 8'd0;
        forever begin
            @(posedge clock);
            ar_hs = s_arvalid & s_arready; r_hs = s_rvalid & s_rready;
            a_cap = s_araddr; id_cap = s_arid; len_cap = s_arlen;
            #1;
            if (reset) begin
                sl_act = 1'b0;
            end else begin
                if (r_hs) begin
                    if (sl_beat == sl_len) sl_act = 1'b0;
                    else sl_beat = sl_beat + 8'd1;
                end
                if (ar_hs) begin
                    sl_act = 1'b1; sl_addr = a_cap; sl_id = id_cap; sl_len = len_cap; sl_beat = 8'd0;
                end
            end
            s_rvalid = sl_act;
            s_rdata  = sl_addr + 32'(sl_beat);
            s_rlast  = sl_act && (sl_beat == sl_len);
            s_rid    = (corrupt0 && sl_beat == 8'd0) ? 4'd2 : sl_id;
        end
    end

    // Monitor: compare every AR handshake and every delivered R beat against the scoreboard
    always @(negedge clock) begin
        if (!reset) begin
            if (s_arvalid && s_arready) begin
                if (ar_q.size() == 0) chk("ar_unexpected", 64'd1, 64'd0);
                else begin
                    ea = ar_q.pop_front();
                    chk("ar_grant", 64'(m1_arready), 64'(ea.m));
                    chk("ar_one_ready", 64'(m0_arready & m1_arready), 64'd0);
                    chk("ar_addr", 64'(s_araddr), 64'(ea.addr));
                    chk("ar_id", 64'(s_arid), 64'(ea.id));
                    chk("ar_len", 64'(s_arlen), 64'(ea.len));
                end
            end
            if (m0_rvalid && m1_rvalid) chk("r_both_valid", 64'd1, 64'd0);
            if ((m0_rvalid && m0_rready) || (m1_rvalid && m1_rready)) begin
                if (r_q.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
                else begin
                    er = r_q.pop_front();
                    chk("r_master", 64'(m1_rvalid), 64'(er.m));
                    chk("r_data", 64'(m1_rvalid ? m1_rdata : m0_rdata), 64'(er.data));
                    chk("r_rid", 64'(m1_rvalid ? m1_rid : m0_rid), 64'(er.rid));
                    chk("r_last", 64'(m1_rvalid ? m1_rlast : m0_rlast), 64'(er.last));
                end
            end
        end
    end

    task automatic req(input bit m, input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        bit done = 1'b0;
        if (m) begin m1_araddr = a; m1_arid = id; m1_arlen = len; m1_arvalid = 1'b1; end
        else   begin m0_araddr = a; m0_arid = id; m0_arlen = len; m0_arvalid = 1'b1; end
        for (int c = 0; c < 300 && !done; c++) begin
            @(posedge clock);
            if (m ? (m1_arvalid && m1_arready) : (m0_arvalid && m0_arready)) done = 1'b1;
        end
        #1;
        if (m) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
        if (!done) chk("ar_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int c = 0; c < 500 && !ok; c++) begin
            @(negedge clock);
            if (!busy && ar_q.size() == 0 && r_q.size() == 0) ok = 1'b1;
        end
        if (!ok) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        bit found;
        reset = 1'b1;
        m0_araddr = 32'd0; m0_arid = 4'd0; m0_arlen = 8'd0; m0_arsize = 3'd2; m0_arburst = 2'd1;
        m1_araddr = 32'd0; m1_arid = 4'd0; m1_arlen = 8'd0; m1_arsize = 3'd3; m1_arburst = 2'd1;
        m0_arvalid = 1'b0; m1_arvalid = 1'b0; m0_rready = 1'b1; m1_rready = 1'b1; s_arready = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_s_arvalid", 64'(s_arvalid), 64'd0);
        chk("rst_s_rready", 64'(s_rready), 64'd0);
        chk("rst_s_araddr", 64'(s_araddr), 64'd0);
        chk("rst_rid_err", 64'(rid_err), 64'd0);

        // single m0 burst, busy low the cycle after rlast
        push_exp(1'b0, 32'h8000_0008, 4'd1, 8'd1, 1'b0);
        req(1'b0, 32'h8000_0008, 4'd1, 8'd1);
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clock);
            if (m0_rvalid && m0_rready && m0_rlast) found = 1'b1;
        end
        chk("t1_rlast_seen", 64'(found), 64'd1);
        @(negedge clock);
        chk("t1_busy_after_rlast", 64'(busy), 64'd0);
        wait_idle();

        // simultaneous request: m1 first, m0 only after m1's burst
        push_exp(1'b1, 32'h9000_0000, 4'd3, 8'd2, 1'b0);
        push_exp(1'b0, 32'h8000_0100, 4'd2, 8'd0, 1'b0);
        fork
            req(1'b0, 32'h8000_0100, 4'd2, 8'd0);
            req(1'b1, 32'h9000_0000, 4'd3, 8'd2);
        join
        wait_idle();

        // AR abort by m0 while slave stalls; waiting m1 then served
        push_exp(1'b1, 32'h9000_0040, 4'd6, 8'd0, 1'b0);
        fork
            begin
                s_arready = 1'b0;
                m0_araddr = 32'h8000_0300; m0_arid = 4'd4; m0_arlen = 8'd0; m0_arvalid = 1'b1;
                @(posedge clock); #1;
                @(negedge clock);
                chk("t4_busy_ar", 64'(busy), 64'd1);
                chk("t4_s_arvalid", 64'(s_arvalid), 64'd1);
                chk("t4_s_araddr", 64'(s_araddr), 64'h8000_0300);
                chk("t4_m0_arready", 64'(m0_arready), 64'd0);
                chk("t4_m1_arready", 64'(m1_arready), 64'd0);
                @(posedge clock); #1;
                m0_arvalid = 1'b0;
                #1 chk("t4_abort_s_arvalid", 64'(s_arvalid), 64'd0);
                @(negedge clock);
                @(negedge clock);
                chk("t4_idle_after_abort", 64'(busy), 64'd0);
                chk("t4_no_r_m0", 64'(m0_rvalid), 64'd0);
                s_arready = 1'b1;
            end
            begin
                @(posedge clock); #1;
                req(1'b1, 32'h9000_0040, 4'd6, 8'd0);
            end
        join
        wait_idle();
        chk("t4_rid_err_clean", 64'(rid_err), 64'd0);

        // rid mismatch on beat 0: beat still delivered, error sticky
        corrupt0 = 1'b1;
        push_exp(1'b0, 32'h8000_0200, 4'd1, 8'd1, 1'b1);
        req(1'b0, 32'h8000_0200, 4'd1, 8'd1);
        wait_idle();
        corrupt0 = 1'b0;
        chk("t5_rid_err_set", 64'(rid_err), 64'd1);
        push_exp(1'b1, 32'h9000_0080, 4'd7, 8'd1, 1'b0);
        req(1'b1, 32'h9000_0080, 4'd7, 8'd1);
        wait_idle();
        chk("t5_rid_err_sticky", 64'(rid_err), 64'd1);

        // reset in the middle of a burst
        push_exp(1'b0, 32'h8000_0400, 4'd5, 8'd1, 1'b0);
        req(1'b0, 32'h8000_0400, 4'd5, 8'd1);
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clock);
            if (m0_rvalid && m0_rready) found = 1'b1;
        end
        chk("t6_beat0_seen", 64'(found), 64'd1);
        @(posedge clock); #2;
        reset = 1'b1;
        #1;
        chk("t6_s_rready", 64'(s_rready), 64'd0);
        chk("t6_m0_rvalid", 64'(m0_rvalid), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        r_q.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("t6_busy_after", 64'(busy), 64'd0);
        chk("t6_rid_err_after", 64'(rid_err), 64'd0);

        // both masters keep requesting for four bursts
`ifdef YSYX_23060229_ARB_RR_EN
        push_exp(1'b0, 32'h8000_1000, 4'd1, 8'd1, 1'b0);
        push_exp(1'b1, 32'h9000_1000, 4'd2, 8'd1, 1'b0);
        push_exp(1'b0, 32'h8000_2000, 4'd3, 8'd0, 1'b0);
        push_exp(1'b1, 32'h9000_2000, 4'd4, 8'd0, 1'b0);
`else
        push_exp(1'b1, 32'h9000_1000, 4'd2, 8'd1, 1'b0);
        push_exp(1'b1, 32'h9000_2000, 4'd4, 8'd0, 1'b0);
        push_exp(1'b0, 32'h8000_1000, 4'd1, 8'd1, 1'b0);
        push_exp(1'b0, 32'h8000_2000, 4'd3, 8'd0, 1'b0);
`endif
        fork
            begin req(1'b0, 32'h8000_1000, 4'd1, 8'd1); req(1'b0, 32'h8000_2000, 4'd3, 8'd0); end
            begin req(1'b1, 32'h9000_1000, 4'd2, 8'd1); req(1'b1, 32'h9000_2000, 4'd4, 8'd0); end
        join
        wait_idle();

        chk("end_ar_queue_empty", 64'(ar_q.size()), 64'd0);
        chk("end_r_queue_empty", 64'(r_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
